// File: rtl/uart_rx_feeder.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_feeder
// Description : 8N1 UART receiver (16x oversampling) with a byte FIFO that
//               feeds the command parser with gap-limited data strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_feeder #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int MIN_GAP    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    input  logic                          pause,
    output logic [7:0]                    data,
    output logic                          dataReady,
    output logic                          frameError,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

    localparam int c_DIV      = CLK_HZ / (BAUD * 16);
    localparam int c_DW       = (c_DIV < 2) ? 1 : $clog2(c_DIV);
    localparam int c_DIV_M1   = c_DIV - 1;
    localparam logic [c_DW-1:0] c_DIV_LAST = c_DIV_M1[c_DW-1:0];
    localparam int c_AW       = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0] c_FULL = FIFO_DEPTH[c_AW:0];
    localparam int c_GW       = $clog2(MIN_GAP + 1);
    localparam logic [c_GW-1:0] c_GAP = MIN_GAP[c_GW-1:0];

    generate
        if (c_DIV < 2) begin : g_div_check
            $error("uart_rx_feeder: CLK_HZ/(BAUD*16) must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    logic              r_sync1, r_rxs;
    logic [c_DW-1:0]   r_div;
    logic              w_tick;
    state_t            r_state, w_state_nxt;
    logic [3:0]        r_sc, w_sc_nxt;
    logic [2:0]        r_bc, w_bc_nxt;
    logic [7:0]        r_shift, w_shift_nxt;
    logic              w_go_start, w_stop_ok, w_stop_bad;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wptr, r_rptr;
    logic [c_AW:0]     r_count;
    logic [c_GW-1:0]   r_gap;
    logic              w_pop, w_push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_rxs   <= r_sync1;
        end
    end

    // Realigning the divider at the start edge puts sc==7 at the start-bit centre.
    assign w_tick = (r_div == c_DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_div <= '0;
        else if (w_go_start || w_tick)
            r_div <= '0;
        else
            r_div <= r_div + c_DW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sc    <= '0;
            r_bc    <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sc    <= w_sc_nxt;
            r_bc    <= w_bc_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sc_nxt    = r_sc;
        w_bc_nxt    = r_bc;
        w_shift_nxt = r_shift;
        w_go_start  = 1'b0;
        w_stop_ok   = 1'b0;
        w_stop_bad  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rxs) begin
                    w_state_nxt = S_START;
                    w_sc_nxt    = '0;
                    w_go_start  = 1'b1;
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (r_sc == 4'd7) begin
                        if (r_rxs) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_DATA;
                            w_sc_nxt    = '0;
                            w_bc_nxt    = '0;
                        end
                    end else begin
                        w_sc_nxt = r_sc + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_sc_nxt = r_sc + 4'd1;
                    if (r_sc == 4'd15) begin
                        w_shift_nxt = {r_rxs, r_shift[7:1]};
                        w_bc_nxt    = r_bc + 3'd1;
                        if (r_bc == 3'd7)
                            w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_sc_nxt = r_sc + 4'd1;
                    if (r_sc == 4'd15) begin
                        if (r_rxs) begin
                            w_stop_ok   = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_stop_bad  = 1'b1;
                            w_state_nxt = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (r_rxs)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_pop  = (r_count != '0) && !pause && (r_gap >= c_GAP);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push = w_stop_ok && ((r_count < c_FULL) || w_pop);

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= r_shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_gap      <= c_GAP;
            data       <= '0;
            dataReady  <= 1'b0;
            frameError <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + c_AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_pop)
                r_gap <= c_GW'(1);
            else if (r_gap != c_GAP)
                r_gap <= r_gap + c_GW'(1);
            if (w_pop)
                data <= r_mem[r_rptr];
            dataReady  <= w_pop;
            frameError <= w_stop_bad;
            if (w_stop_ok && !w_push)
                overflow <= 1'b1;
        end
    end

    assign fifoCount = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_feeder
// Description : Directed self-checking bench for uart_rx_feeder at DIV=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_feeder;

    localparam int c_BAUD = 115200;
    localparam int c_CLK  = 64 * c_BAUD;
    localparam int c_BIT  = 64;

    logic       clk, rst, rxd, pause;
    logic [7:0] data;
    logic       dataReady, frameError, overflow;
    logic [4:0] fifoCount;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fe_cnt = 0;
    int dr_consec = 0;
    logic prev_dr = 1'b0;
    logic [7:0] rx_q[$];
    int rx_cyc[$];

    uart_rx_feeder #(
        .CLK_HZ(c_CLK), .BAUD(c_BAUD), .FIFO_DEPTH(16), .MIN_GAP(2)
    ) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .pause(pause),
        .data(data), .dataReady(dataReady), .frameError(frameError),
        .overflow(overflow), .fifoCount(fifoCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dataReady) begin
            rx_q.push_back(data);
            rx_cyc.push_back(cyc);
        end
        if (frameError) fe_cnt++;
        if (dataReady && prev_dr) dr_consec++;
        prev_dr = dataReady;
    end

    task automatic line(input logic v, input int n);
        rxd = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopb);
        line(1'b0, c_BIT);
        for (int i = 0; i < 8; i++) line(b[i], c_BIT);
        line(stopb, c_BIT);
    endtask

    task automatic clear_mon();
        rx_q.delete();
        rx_cyc.delete();
        fe_cnt = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL %s data got %h want 00", tag, data); end
        checks++; if (dataReady !== 1'b0) begin errors++; $display("FAIL %s dataReady got %b want 0", tag, dataReady); end
        checks++; if (frameError !== 1'b0) begin errors++; $display("FAIL %s frameError got %b want 0", tag, frameError); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL %s overflow got %b want 0", tag, overflow); end
        checks++; if (fifoCount !== 5'd0) begin errors++; $display("FAIL %s fifoCount got %0d want 0", tag, fifoCount); end
    endtask

    task automatic test_reset();
        check_idle_outputs("reset_held");
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_idle_outputs("reset_released");
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        clear_mon();
        send_frame(8'h1B, 1'b1);
        send_frame(8'h5B, 1'b1);
        line(1'b1, 50);
        checks++; if (rx_q.size() != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", rx_q.size()); end
        v = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
        checks++; if (v !== 8'h1B) begin errors++; $display("FAIL b2b_byte0 got %h want 1b", v); end
        v = (rx_q.size() > 1) ? rx_q[1] : 8'hxx;
        checks++; if (v !== 8'h5B) begin errors++; $display("FAIL b2b_byte1 got %h want 5b", v); end
        checks++; if (fe_cnt != 0) begin errors++; $display("FAIL b2b_frameError got %0d want 0", fe_cnt); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow got %b want 0", overflow); end
    endtask

    task automatic test_start_glitch();
        clear_mon();
        line(1'b0, 20);
        line(1'b1, 200);
        checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL glitch_strobes got %0d want 0", rx_q.size()); end
        checks++; if (fifoCount !== 5'd0) begin errors++; $display("FAIL glitch_count got %0d want 0", fifoCount); end
        checks++; if (fe_cnt != 0) begin errors++; $display("FAIL glitch_frameError got %0d want 0", fe_cnt); end
    endtask

    task automatic test_frame_error();
        logic [7:0] v;
        clear_mon();
        send_frame(8'h41, 1'b0);
        line(1'b0, 40 * c_BIT);
        line(1'b1, c_BIT);
        send_frame(8'h42, 1'b1);
        line(1'b1, 50);
        checks++; if (fe_cnt != 1) begin errors++; $display("FAIL fe_pulses got %0d want 1", fe_cnt); end
        checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL fe_strobes got %0d want 1", rx_q.size()); end
        v = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
        checks++; if (v !== 8'h42) begin errors++; $display("FAIL fe_byte got %h want 42", v); end
    endtask

    task automatic test_drain_spacing();
        int p;
        int c;
        logic [7:0] v;
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h31; exp_b[1] = 8'h32; exp_b[2] = 8'h33;
        clear_mon();
        dr_consec = 0;
        pause = 1'b1;
        for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1);
        line(1'b1, 20);
        checks++; if (fifoCount !== 5'd3) begin errors++; $display("FAIL drain_fill got %0d want 3", fifoCount); end
        checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL drain_paused got %0d want 0", rx_q.size()); end
        pause = 1'b0;
        p = cyc;
        line(1'b1, 20);
        for (int i = 0; i < 3; i++) begin
            c = (rx_cyc.size() > i) ? rx_cyc[i] : -1;
            v = (rx_q.size() > i) ? rx_q[i] : 8'hxx;
            checks++; if (c != p + 1 + 2 * i) begin errors++; $display("FAIL drain_cycle%0d got P+%0d want P+%0d", i, c - p, 1 + 2 * i); end
            checks++; if (v !== exp_b[i]) begin errors++; $display("FAIL drain_byte%0d got %h want %h", i, v, exp_b[i]); end
        end
        checks++; if (fifoCount !== 5'd0) begin errors++; $display("FAIL drain_empty got %0d want 0", fifoCount); end
        checks++; if (dr_consec != 0) begin errors++; $display("FAIL drain_consecutive got %0d want 0", dr_consec); end
    endtask

    task automatic test_overflow();
        logic [7:0] v;
        clear_mon();
        pause = 1'b1;
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1);
        checks++; if (fifoCount !== 5'd16) begin errors++; $display("FAIL ovf_full got %0d want 16", fifoCount); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", overflow); end
        send_frame(8'h10, 1'b1);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
        checks++; if (fifoCount !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d want 16", fifoCount); end
        pause = 1'b0;
        line(1'b1, 80);
        checks++; if (rx_q.size() != 16) begin errors++; $display("FAIL ovf_strobes got %0d want 16", rx_q.size()); end
        for (int i = 0; i < 16; i++) begin
            v = (rx_q.size() > i) ? rx_q[i] : 8'hxx;
            checks++; if (v !== 8'(i)) begin errors++; $display("FAIL ovf_byte%0d got %h want %h", i, v, 8'(i)); end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        checks++; if (fifoCount !== 5'd0) begin errors++; $display("FAIL ovf_drained got %0d want 0", fifoCount); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] v;
        logic [7:0] b;
        clear_mon();
        pause = 1'b1;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        checks++; if (fifoCount !== 5'd2) begin errors++; $display("FAIL rstmid_queued got %0d want 2", fifoCount); end
        b = 8'h55;
        line(1'b0, c_BIT);
        for (int i = 0; i < 3; i++) line(b[i], c_BIT);
        line(b[3], c_BIT / 2);
        rst = 1'b1;
        #1;
        check_idle_outputs("rstmid_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        rxd = 1'b1;
        pause = 1'b0;
        line(1'b1, 2 * c_BIT);
        send_frame(8'hAA, 1'b1);
        line(1'b1, 50);
        checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL rstmid_strobes got %0d want 1", rx_q.size()); end
        v = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
        checks++; if (v !== 8'hAA) begin errors++; $display("FAIL rstmid_byte got %h want aa", v); end
        checks++; if (fe_cnt != 0) begin errors++; $display("FAIL rstmid_frameError got %0d want 0", fe_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        pause = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_back_to_back();
        test_start_glitch();
        test_frame_error();
        test_drain_spacing();
        test_overflow();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_feeder.md
# uart_rx_feeder

Serial front end of the virtual console. It receives 8N1 UART frames on `rxd` using 16x oversampling and buffers the received bytes in a small FIFO. It delivers them to the command parser as single-cycle `data`/`dataReady` strobes, spaced so that no byte is lost while the parser is clearing its `commandReady` pulse. It sits between the board's serial pin and the parser's `data`/`dataReady` inputs.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency.
- `BAUD`, 115200: line rate.
- `FIFO_DEPTH`, 16: byte buffer depth; power of two, at least 2.
- `MIN_GAP`, 2: minimum number of cycles from one `dataReady` assertion to the next; at least 2.
- Derived: `DIV = CLK_HZ / (BAUD*16)`, integer division. `DIV` must be at least 2; elaboration fails otherwise.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `rxd` in 1: raw serial input; idle level is high.
- `pause` in 1: while high, no byte leaves the FIFO. Reception continues.
- `data` out 8: byte being delivered; meaningful only while `dataReady` is high.
- `dataReady` out 1: single-cycle strobe that delivers `data`.
- `frameError` out 1: single-cycle pulse when a stop bit samples low.
- `overflow` out 1: sticky; set when a byte is dropped because the FIFO is full; cleared only by `rst`.
- `fifoCount` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **Input synchronizer:** `rxd` passes through a 2-flop synchronizer with both flops reset to 1. All logic uses the synchronized value `rxs`.
- **Tick generator:** a counter from 0 to DIV-1 produces a one-cycle `tick` whenever it wraps. The counter is forced to 0 on the IDLE->START transition.
- **Receive FSM:** states IDLE, START, DATA, STOP, WAIT_IDLE. A 4-bit sample counter `sc` counts ticks and a 3-bit counter `bc` counts data bits.
  - IDLE: when `rxs` is 0, go to START with `sc=0`.
  - START: on the 8th tick (`sc==7`), check `rxs`. If it is 1, treat it as a glitch and return to IDLE. If it is 0, set `sc=0` and go to DATA with `bc=0`.
  - DATA: every 16th tick (bit midpoint), shift `rxs` into the shift register LSB-first. After bit 7, go to STOP.
  - STOP: on the 16th tick, sample `rxs`.
    - If it is 1, push the shift register into the FIFO and go to IDLE.
    - If it is 0, pulse `frameError`, discard the byte and go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rxs` is 1, then go to IDLE. A held break therefore produces only one error.
- **FIFO push:** the push occurs in the same cycle as the stop-bit sample.
  - A push is accepted if `fifoCount < FIFO_DEPTH`, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and `overflow` is set.
- **FIFO pop:** a pop occurs in a cycle where all of the following hold: the FIFO is non-empty, `pause` is low, and the gap counter shows at least MIN_GAP cycles since the last `dataReady` (or no `dataReady` has occurred since reset).
  - On a pop, the head byte is registered into `data` and `dataReady` is high for the next cycle.
  - `data` holds its last value afterwards.
- **Simultaneous push and pop:** both take effect and `fifoCount` is unchanged.
- **Pointers:** read and write pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.

## Timing
- **Reset values:** `data=0`, `dataReady=0`, `frameError=0`, `overflow=0`, `fifoCount=0`. FSM in IDLE, synchronizer flops at 1, pointers at 0, gap counter saturated (first byte is not delayed).
- **Reset mid-frame:** discards the partial byte and FIFO contents immediately (asynchronous). Reception resumes at the next falling edge after `rst` deasserts.
- **Latency:**
  - Stop-bit sample edge (push) at cycle N; `fifoCount` updates at N+1.
  - Pop decision at N+1; `dataReady` is high during cycle N+2, provided the FIFO was empty and the gap and `pause` conditions allow it.
  - `rxd` to `rxs` adds 2 cycles.
- **Strobe spacing:** `dataReady` is never high in two consecutive cycles. With MIN_GAP=2, the maximum drain rate is one byte every 2 cycles.
- **`pause`:** rising during a cycle blocks the pop decided in that cycle. A strobe already registered still completes.
- **`frameError`:** high for exactly the cycle after the stop-bit sample.
- **Mid-bit sampling:** sampling occurs at sc=7 for the start bit and every 16 ticks after that, i.e. mid-bit. This tolerates ±3% baud mismatch.

## Test plan
All scenarios use DIV=4 (CLK_HZ = 64*BAUD).
- **Back-to-back frames:** send 0x1B then 0x5B back-to-back -> exactly two `dataReady` pulses, `data=0x1B` then `0x5B`; `frameError` and `overflow` stay 0.
- **Start glitch:** drive `rxd` low for 5 ticks (20 cycles), then high -> FSM returns to IDLE; no `dataReady`; `fifoCount=0`.
- **Framing error:** send 0x41 with a stop bit of 0 and hold `rxd` low for 40 bit times, then send 0x42 -> one `frameError` pulse; no byte for 0x41; one `dataReady` with `data=0x42`.
- **Drain spacing:** hold `pause`=1 while sending 0x31, 0x32, 0x33 (`fifoCount` reaches 3), then drop `pause` at cycle P -> `dataReady` high at P+1, P+3 and P+5 with 0x31, 0x32, 0x33; `fifoCount` ends at 0.
- **Overflow:** hold `pause`=1 while sending 17 bytes 0x00..0x10 -> `fifoCount=16`; `overflow` rises at the 17th stop bit and stays 1; after releasing `pause`, 16 bytes 0x00..0x0F are delivered and 0x10 is lost.
- **Reset mid-frame:** assert `rst` for 1 cycle during bit 3 of 0x55, with 2 bytes queued -> all outputs return to reset values immediately; a following frame 0xAA is delivered once, intact.
